alu_multicycle: RTL and testbench

//  Execute unit that consumes the 4-bit ALU control code produced by the ALU decoder and

---
 rtl/alu_multicycle.sv | 162 ++++++++++++++++
 tb/tb_alu_multicycle.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// Execute-stage ALU with valid/ready handshakes; single-cycle ops finish in one cycle.
// Define ALU_MUL_EN to build the iterative shift-add multiplier for code 1001.
module alu_multicycle #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             branch_taken,
    output logic             zero
);
    localparam int unsigned SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_BEQ  = 4'b1000;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_MUL  = 4'b1001;
    localparam logic [3:0] OP_BNE  = 4'b1010;
    localparam logic [3:0] OP_BLT  = 4'b1011;
    localparam logic [3:0] OP_BGE  = 4'b1100;
    localparam logic [3:0] OP_BLTU = 4'b1110;
    localparam logic [3:0] OP_BGEU = 4'b1111;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
    state_t state, state_next;

    logic             accept;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] diff;
    logic             lt_s, lt_u;
    logic [WIDTH-1:0] alu_res;
    logic             alu_taken;

`ifdef ALU_MUL_EN
    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);
    logic [WIDTH-1:0] acc, mcand, mplier, acc_step;
    logic [SHW-1:0]   cnt;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
`ifdef ALU_MUL_EN
                    state_next = (alu_control == OP_MUL) ? S_MUL : S_DONE;
`else
                    state_next = S_DONE;
`endif
                end
            end
`ifdef ALU_MUL_EN
            S_MUL:  if (cnt == LAST) state_next = S_DONE;
`endif
            S_DONE: if (out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == S_IDLE);
        out_valid = (state == S_DONE);
        accept    = in_valid & in_ready;
    end

    // Single-cycle datapath works straight off the ports; it is only sampled on accept.
    always_comb begin
        shamt     = src_b[SHW-1:0];
        diff      = src_a - src_b;
        lt_s      = $signed(src_a) < $signed(src_b);
        lt_u      = src_a < src_b;
        alu_res   = '0;
        alu_taken = 1'b0;
        case (alu_control)
            OP_ADD:  alu_res = src_a + src_b;
            OP_AND:  alu_res = src_a & src_b;
            OP_OR:   alu_res = src_a | src_b;
            OP_XOR:  alu_res = src_a ^ src_b;
            OP_SLL:  alu_res = src_a << shamt;
            OP_SRL:  alu_res = src_a >> shamt;
            OP_SRA:  alu_res = $signed(src_a) >>> shamt;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, lt_s};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, lt_u};
            OP_MUL:  alu_res = '0;
            OP_BEQ:  begin alu_res = diff; alu_taken = (src_a == src_b); end
            OP_BNE:  begin alu_res = diff; alu_taken = (src_a != src_b); end
            OP_BLT:  begin alu_res = diff; alu_taken = lt_s;  end
            OP_BGE:  begin alu_res = diff; alu_taken = !lt_s; end
            OP_BLTU: begin alu_res = diff; alu_taken = lt_u;  end
            OP_BGEU: begin alu_res = diff; alu_taken = !lt_u; end
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_MUL_EN
    always_comb acc_step = acc + (mplier[0] ? mcand : '0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            result       <= '0;
            branch_taken <= 1'b0;
            zero         <= 1'b0;
`ifdef ALU_MUL_EN
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
`endif
        end else if (accept) begin
`ifdef ALU_MUL_EN
            if (alu_control == OP_MUL) begin
                acc    <= '0;
                mcand  <= src_a;
                mplier <= src_b;
                cnt    <= '0;
            end else begin
                result       <= alu_res;
                branch_taken <= alu_taken;
                zero         <= (alu_res == '0);
            end
`else
            result       <= alu_res;
            branch_taken <= alu_taken;
            zero         <= (alu_res == '0);
`endif
        end
`ifdef ALU_MUL_EN
        else if (state == S_MUL) begin
            acc    <= acc_step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (cnt == LAST) begin
                result       <= acc_step;
                branch_taken <= 1'b0;
                zero         <= (acc_step == '0);
            end
        end
`endif
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Randomized self-checking bench for alu_multicycle against a plain-arithmetic reference.
// Follows ALU_MUL_EN the same way the design does.
module tb_alu_multicycle;
    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset, in_valid, in_ready, out_valid, out_ready, branch_taken, zero;
    logic [3:0]   alu_control;
    logic [W-1:0] src_a, src_b, result;
    int           n_tests = 0;
    int           n_fail  = 0;

    always #5 clk = ~clk;

    alu_multicycle #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .alu_control(alu_control), .src_a(src_a), .src_b(src_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .branch_taken(branch_taken), .zero(zero)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic t);
        logic [63:0] wide;
        logic [4:0]  sh;
        sh = b[4:0];
        r  = 32'd0;
        t  = 1'b0;
        case (op)
            4'd0:  r = a + b;
            4'd7:  r = a & b;
            4'd6:  r = a | b;
            4'd4:  r = a ^ b;
            4'd1:  r = a << sh;
            4'd5:  r = a >> sh;
            4'd13: begin wide = {{32{a[31]}}, a} >> sh; r = wide[31:0]; end
            4'd2:  r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd3:  r = (a < b) ? 32'd1 : 32'd0;
            4'd9: begin
`ifdef ALU_MUL_EN
                wide = 64'(a) * 64'(b);
                r = wide[31:0];
`else
                r = 32'd0;
`endif
            end
            default: begin
                r = a - b;
                case (op)
                    4'd8:  t = (a == b);
                    4'd10: t = (a != b);
                    4'd11: t = int'(a) < int'(b);
                    4'd12: t = int'(a) >= int'(b);
                    4'd14: t = a < b;
                    default: t = a >= b;
                endcase
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [3:0] op);
`ifdef ALU_MUL_EN
        return (op == 4'd9) ? int'(W) + 1 : 1;
`else
        return (op == 4'd9) ? 1 : 1;
`endif
    endfunction

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input bit early);
        logic [31:0] er;
        logic        et;
        int          lat;
        bit          busy_ok;
        model(op, a, b, er, et);
        @(negedge clk);
        check_eq("in_ready_idle", 64'(in_ready), 64'd1);
        in_valid = 1'b1; alu_control = op; src_a = a; src_b = b; out_ready = early;
        @(posedge clk); #1;
        in_valid = 1'b0; alu_control = 4'($urandom); src_a = $urandom; src_b = $urandom;
        lat = 0; busy_ok = 1'b1;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
            if (in_ready) busy_ok = 1'b0;
        end
        check_eq("latency", 64'(lat), 64'(exp_lat(op)));
        if (lat > 1) check_eq("busy_in_ready_low", 64'(busy_ok), 64'd1);
        check_eq("result", 64'(result), 64'(er));
        check_eq("branch_taken", 64'(branch_taken), 64'(et));
        check_eq("zero", 64'(zero), 64'(er == 32'd0));
        if (!early) begin
            for (int i = 0; i < hold; i++) begin
                in_valid = 1'b1; alu_control = 4'($urandom); src_a = $urandom; src_b = $urandom;
                @(negedge clk);
            end
            if (hold > 0) begin
                check_eq("held_result", 64'(result), 64'(er));
                check_eq("held_out_valid", 64'(out_valid), 64'd1);
                check_eq("held_in_ready", 64'(in_ready), 64'd0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(negedge clk);
        check_eq("release_out_valid", 64'(out_valid), 64'd0);
        check_eq("release_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b0;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check_eq({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        check_eq({tag, "_result"}, 64'(result), 64'd0);
        check_eq({tag, "_zero"}, 64'(zero), 64'd0);
        check_eq({tag, "_taken"}, 64'(branch_taken), 64'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        alu_control = 4'd0; src_a = '0; src_b = '0;
        repeat (3) @(negedge clk);
        check_reset_state("por");
        reset = 1'b0;

        run_op(4'd0,  32'd7, 32'd5, 0, 1'b0);
        run_op(4'd8,  32'h55, 32'h55, 2, 1'b0);
        run_op(4'd14, 32'd1, 32'hFFFF_FFFF, 0, 1'b1);
        run_op(4'd11, 32'd1, 32'hFFFF_FFFF, 0, 1'b0);
        run_op(4'd13, 32'h8000_0000, 32'd4, 1, 1'b0);
        run_op(4'd5,  32'h8000_0000, 32'd4, 0, 1'b1);
        run_op(4'd1,  32'd1, 32'h25, 0, 1'b0);
        run_op(4'd9,  32'hFFFF_FFFF, 32'd3, 10, 1'b0);

        // Reset while the mul iterates (or while sitting in DONE without the multiplier).
        @(negedge clk);
        in_valid = 1'b1; alu_control = 4'd9; src_a = 32'h1234_5678; src_b = 32'h9ABC_DEF1;
        @(posedge clk); #1;
        repeat (10) @(negedge clk);
        reset = 1'b1; in_valid = 1'b1; alu_control = 4'd0;
        @(negedge clk);
        check_reset_state("mid_reset");
        reset = 1'b0; in_valid = 1'b0;
        run_op(4'd0, 32'd7, 32'd5, 0, 1'b0);

        for (int n = 0; n < 150; n++) begin
            ra = pick_operand();
            rb = pick_operand();
            run_op(4'($urandom_range(0, 15)), ra, rb, int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
